// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: an internal prescaler steps an N_LED-wide bank through
// drain, fill, chase or bounce patterns, with optional bit-mirroring and run/pause.
module led_pattern_seq #(
  parameter int          N_LED = 8,
  parameter int unsigned DIV   = 25_000_000
) (
  input  logic             CLK,
  input  logic             rs,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             run,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             cycle_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(2 * N_LED);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
  localparam logic [N_LED-1:0] ONES     = '1;
  localparam logic [N_LED-1:0] ONE      = N_LED'(1);

  typedef enum logic [1:0] {
    DRAIN  = 2'b00,
    FILL   = 2'b01,
    CHASE  = 2'b10,
    BOUNCE = 2'b11
  } mode_t;

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pos;
  mode_t            mode_q;
  logic             dir_q;
  logic [PW-1:0]    pos_last;
  logic [PW-1:0]    pos_next;
  logic [N_LED-1:0] base;
  logic [N_LED-1:0] mirrored;
  logic [N_LED-1:0] led_next;

  // Last legal position of the active pattern; anything at or beyond it wraps.
  always_comb begin
    pos_last = '0;
    case (mode_q)
      DRAIN:   pos_last = PW'(N_LED);
      FILL:    pos_last = PW'(N_LED);
      CHASE:   pos_last = PW'(N_LED - 1);
      BOUNCE:  pos_last = PW'(2 * N_LED - 3);
      default: pos_last = '0;
    endcase
    pos_next = (pos >= pos_last) ? '0 : pos + 1'b1;
  end

  always_comb begin
    base = '0;
    case (mode_q)
      DRAIN:   base = ONES << pos;
      FILL:    base = ~(ONES << pos);
      CHASE:   base = ONE << pos;
      BOUNCE:  base = (pos < PW'(N_LED)) ? (ONE << pos)
                                         : (ONE << (PW'(2 * N_LED - 2) - pos));
      default: base = '0;
    endcase
    mirrored = '0;
    for (int i = 0; i < N_LED; i++) begin
      mirrored[i] = base[N_LED-1-i];
    end
    led_next = dir_q ? mirrored : base;
  end

  // A mode change restarts the pattern and swallows any coincident tick.
  always_ff @(posedge CLK or negedge rs) begin
    if (!rs) begin
      cnt        <= '0;
      pos        <= '0;
      mode_q     <= DRAIN;
      dir_q      <= 1'b0;
      led        <= '1;
      step       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      led        <= led_next;
      dir_q      <= dir;
      step       <= 1'b0;
      cycle_done <= 1'b0;
      if (mode != mode_q) begin
        mode_q <= mode_t'(mode);
        pos    <= '0;
        cnt    <= '0;
      end else if (run) begin
        if (cnt == CNT_LAST) begin
          cnt        <= '0;
          pos        <= pos_next;
          step       <= 1'b1;
          cycle_done <= (pos_next == '0);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with N_LED=8, DIV=4: each scenario task
// drives inputs on the falling edge and checks outputs there against hand values.
module tb_led_pattern_seq;

  localparam int          N_LED = 8;
  localparam int unsigned DIV   = 4;

  logic             CLK  = 1'b0;
  logic             rs   = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             dir  = 1'b0;
  logic             run  = 1'b0;
  logic [N_LED-1:0] led;
  logic             step;
  logic             cycle_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  led_pattern_seq #(.N_LED(N_LED), .DIV(DIV)) dut (
    .CLK        (CLK),
    .rs         (rs),
    .mode       (mode),
    .dir        (dir),
    .run        (run),
    .led        (led),
    .step       (step),
    .cycle_done (cycle_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_step(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (step === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rs = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (led !== 8'hFF) $display("FAIL reset_led: got %h expected ff", led);
    else n_pass++;
    n_checks++;
    if (step !== 1'b0) $display("FAIL reset_step: got %b expected 0", step);
    else n_pass++;
    n_checks++;
    if (cycle_done !== 1'b0) $display("FAIL reset_cycle_done: got %b expected 0", cycle_done);
    else n_pass++;
  endtask

  task automatic test_drain;
    logic [7:0] exp_led [9] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFF};
    bit got;
    bit exp_cd;
    int s0;
    rs  = 1'b1;
    run = 1'b1;
    s0  = cyc;
    for (int k = 0; k < 9; k++) begin
      wait_step(got);
      n_checks++;
      if (!got) $display("FAIL drain_step_timeout: step %0d not seen", k);
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (cyc - s0 !== 4) $display("FAIL drain_first_tick: got %0d cycles expected 4", cyc - s0);
        else n_pass++;
      end
      exp_cd = (k == 8);
      n_checks++;
      if (cycle_done !== exp_cd) $display("FAIL drain_cycle_done[%0d]: got %b expected %b", k, cycle_done, exp_cd);
      else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (led !== exp_led[k]) $display("FAIL drain_led[%0d]: got %h expected %h", k, led, exp_led[k]);
      else n_pass++;
    end
  endtask

  task automatic test_fill;
    logic [7:0] exp_led [9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
    bit got;
    bit exp_cd;
    int cd_first;
    mode = 2'b01;
    dir  = 1'b1;
    cd_first = 0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (led !== 8'h00) $display("FAIL fill_start_led: got %h expected 00", led);
    else n_pass++;
    for (int k = 0; k < 18; k++) begin
      wait_step(got);
      n_checks++;
      if (!got) $display("FAIL fill_step_timeout: step %0d not seen", k);
      else n_pass++;
      exp_cd = (k == 8) || (k == 17);
      n_checks++;
      if (cycle_done !== exp_cd) $display("FAIL fill_cycle_done[%0d]: got %b expected %b", k, cycle_done, exp_cd);
      else n_pass++;
      if (k == 8) cd_first = cyc;
      if (k == 17) begin
        n_checks++;
        if (cyc - cd_first !== 36) $display("FAIL fill_cd_period: got %0d cycles expected 36", cyc - cd_first);
        else n_pass++;
      end
      @(negedge CLK);
      n_checks++;
      if (led !== exp_led[k % 9]) $display("FAIL fill_led[%0d]: got %h expected %h", k, led, exp_led[k % 9]);
      else n_pass++;
    end
  endtask

  task automatic test_chase;
    logic [7:0] exp_led [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    bit got;
    bit exp_cd;
    int n_step;
    int n_cd;
    mode = 2'b10;
    dir  = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (led !== 8'h01) $display("FAIL chase_start_led: got %h expected 01", led);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      wait_step(got);
      n_checks++;
      if (!got) $display("FAIL chase_step_timeout: step %0d not seen", k);
      else n_pass++;
      exp_cd = (k == 7);
      n_checks++;
      if (cycle_done !== exp_cd) $display("FAIL chase_cycle_done[%0d]: got %b expected %b", k, cycle_done, exp_cd);
      else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (led !== exp_led[k]) $display("FAIL chase_led[%0d]: got %h expected %h", k, led, exp_led[k]);
      else n_pass++;
    end
    n_step = 0;
    n_cd   = 0;
    repeat (32) begin
      @(negedge CLK);
      if (step === 1'b1) n_step++;
      if (cycle_done === 1'b1) n_cd++;
    end
    n_checks++;
    if (n_step !== 8) $display("FAIL chase_step_count: got %0d expected 8", n_step);
    else n_pass++;
    n_checks++;
    if (n_cd !== 1) $display("FAIL chase_cd_count: got %0d expected 1", n_cd);
    else n_pass++;
  endtask

  task automatic test_bounce;
    logic [7:0] exp_led [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    bit got;
    bit exp_cd;
    int s_step;
    mode = 2'b11;
    dir  = 1'b0;
    s_step = 0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (led !== 8'h01) $display("FAIL bounce_start_led: got %h expected 01", led);
    else n_pass++;
    for (int k = 0; k < 17; k++) begin
      wait_step(got);
      n_checks++;
      if (!got) $display("FAIL bounce_step_timeout: step %0d not seen", k);
      else n_pass++;
      s_step = cyc;
      exp_cd = (k == 13);
      n_checks++;
      if (cycle_done !== exp_cd) $display("FAIL bounce_cycle_done[%0d]: got %b expected %b", k, cycle_done, exp_cd);
      else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (led !== exp_led[k % 14]) $display("FAIL bounce_led[%0d]: got %h expected %h", k, led, exp_led[k % 14]);
      else n_pass++;
    end
    // Position 3 now; mirror the output and confirm the two-edge latency.
    dir = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (led !== 8'h08) $display("FAIL bounce_dir_edge1: got %h expected 08", led);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (led !== 8'h10) $display("FAIL bounce_dir_edge2: got %h expected 10", led);
    else n_pass++;
    wait_step(got);
    n_checks++;
    if (!got) $display("FAIL bounce_dir_step_timeout: step not seen");
    else n_pass++;
    n_checks++;
    if (cyc - s_step !== 4) $display("FAIL bounce_dir_cadence: got %0d cycles expected 4", cyc - s_step);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (led !== 8'h08) $display("FAIL bounce_dir_pos4: got %h expected 08", led);
    else n_pass++;
  endtask

  task automatic test_pause_and_mode_override;
    logic [7:0] exp_led [5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    bit got;
    int r;
    int m;
    mode = 2'b10;
    dir  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_step(got);
      n_checks++;
      if (!got) $display("FAIL pause_step_timeout: step %0d not seen", k);
      else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (led !== exp_led[k]) $display("FAIL pause_led[%0d]: got %h expected %h", k, led, exp_led[k]);
      else n_pass++;
    end
    run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      n_checks++;
      if (led !== 8'h20) $display("FAIL pause_hold_led[%0d]: got %h expected 20", k, led);
      else n_pass++;
      n_checks++;
      if (step !== 1'b0) $display("FAIL pause_hold_step[%0d]: got %b expected 0", k, step);
      else n_pass++;
    end
    run = 1'b1;
    r = cyc;
    wait_step(got);
    n_checks++;
    if (!got) $display("FAIL resume_step_timeout: step not seen");
    else n_pass++;
    n_checks++;
    if (cyc - r !== 3) $display("FAIL resume_remaining: got %0d cycles expected 3", cyc - r);
    else n_pass++;
    repeat (3) @(negedge CLK);
    mode = 2'b00;
    @(negedge CLK);
    m = cyc;
    n_checks++;
    if (step !== 1'b0) $display("FAIL override_step: got %b expected 0", step);
    else n_pass++;
    n_checks++;
    if (cycle_done !== 1'b0) $display("FAIL override_cycle_done: got %b expected 0", cycle_done);
    else n_pass++;
    n_checks++;
    if (led !== 8'h40) $display("FAIL override_led_edge1: got %h expected 40", led);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (led !== 8'hFF) $display("FAIL override_led_edge2: got %h expected ff", led);
    else n_pass++;
    wait_step(got);
    n_checks++;
    if (!got) $display("FAIL override_step_timeout: step not seen");
    else n_pass++;
    n_checks++;
    if (cyc - m !== 4) $display("FAIL override_restart: got %0d cycles expected 4", cyc - m);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (led !== 8'hFE) $display("FAIL override_first_led: got %h expected fe", led);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    bit got;
    mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_step(got);
      n_checks++;
      if (!got) $display("FAIL areset_step_timeout: step %0d not seen", k);
      else n_pass++;
    end
    #1 rs = 1'b0;
    #1;
    n_checks++;
    if (led !== 8'hFF) $display("FAIL areset_led: got %h expected ff", led);
    else n_pass++;
    n_checks++;
    if (step !== 1'b0) $display("FAIL areset_step: got %b expected 0", step);
    else n_pass++;
    n_checks++;
    if (cycle_done !== 1'b0) $display("FAIL areset_cycle_done: got %b expected 0", cycle_done);
    else n_pass++;
    @(negedge CLK);
    rs = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_drain();
    test_fill();
    test_chase();
    test_bounce();
    test_pause_and_mode_override();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
